register_bank: RTL and testbench
================================

# register_bank

Parametrised successor to the core's integer register file. It provides a configurable number of combinational read ports and two prioritised write ports, with optional same-cycle write-to-read bypass and a per-register pending scoreboard. After reset, or on request, a sequential clear engine zeroes the array one entry per cycle, so the storage array never needs reset. It sits between decode (reads, reservations) and writeback (writes) in the integer pipeline.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of registers; power of two, at least 2; AW = $clog2(NREG)
- NRD, 2, number of read ports, 1 to 4
- ZERO_REG, 1, when 1, entry 0 is hard-wired to zero and never written or reserved
- BYPASS, 1, when 1, a read returns the data being written to the same address in the same cycle

Ports (name, direction, width, meaning). The block has one clock. Reset is asynchronous and active-low.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- clear  in  1  request a full re-clear; sampled only in IDLE
- ready  out  1  high in IDLE; low while resetting or clearing
- rden  in  NRD  per-port read enable
- raddr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rdata  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
- rpend  out  NRD  pending bit of each read port's address
- wren  in  2  write enables; port 1 has priority over port 0
- waddr  in  2*AW  write addresses
- wdata  in  2*XLEN  write data
- rsv_en  in  1  reserve a register, setting its pending bit
- rsv_addr  in  AW  address to reserve

## Operation
- State machine states are CLEAR and IDLE. ready = (state == IDLE).
- rst low, asynchronously: state becomes CLEAR, the clear counter becomes 0, and all pending bits become 0.
- CLEAR:
  - Each clock edge writes 0 to entry[counter] and increments the counter.
  - The edge that clears entry NREG-1 moves the state to IDLE.
  - wren and rsv_en are ignored.
  - rdata = 0 and rpend = 0 on every port.
- IDLE with clear = 1: state becomes CLEAR, the counter becomes 0, and all pending bits are cleared on the same edge. That cycle's writes and reservation are discarded.
- Read port i:
  - If rden[i] = 0, or ZERO_REG = 1 and raddr = 0: rdata = 0 and rpend = 0.
  - Otherwise, with BYPASS = 1, rdata takes the first match of: port-1 write to raddr, port-0 write to raddr, array entry.
  - With BYPASS = 0, rdata is always the array entry.
  - rpend is the registered pending bit; it is not bypassed.
- Writes:
  - If both ports write the same address, port 1's data is stored.
  - When ZERO_REG = 1, writes to address 0 are dropped.
  - A write clears the pending bit of its address.
- Reservation: rsv_en sets pending[rsv_addr]. If a write and a reservation hit the same address in the same cycle, the reservation wins and the bit ends at 1. A reservation of address 0 is ignored when ZERO_REG = 1.
- Reset mid-clear restarts the clear sequence at entry 0.

## Timing
- Reads, including rpend, are combinational from raddr/rden to rdata/rpend; there is no latency.
- Writes land on the next rising edge and are visible to array reads in the following cycle. With BYPASS = 1 they are also visible in the same cycle.
- Clear duration is exactly NREG cycles. After rst rises, ready goes high after the NREG-th rising edge and stays high until the next clear or reset.
- Reset values: ready = 0, rdata = 0, rpend = 0, pending bits = 0, counter = 0.
- Array contents are undefined until the clear completes.

## Structure
- The state enum (CLEAR, IDLE) and the register_bank_in_type / register_bank_out_type struct typedefs for the integrating wrapper go in the shared wires package.
- AW is a localparam.
- One sub-module, register_bank_scoreboard, is natural. It holds the NREG pending bits with async reset and provides set, clear and flush ports plus NRD lookup outputs.
- The array and bypass logic stay in register_bank.

## Test plan
- Reset release, NREG=32: ready is 0 for 32 edges and rises after the 32nd. Reads of all 32 addresses then return 0, including entries preset with 0xDEADBEEF by backdoor before reset.
- Write port 0: addr 5 ← 0x12345678, then read addr 5 next cycle on both ports → 0x12345678. Same-cycle read with BYPASS=1 → 0x12345678; with BYPASS=0 → old value 0.
- Dual write to addr 7, port0 = 0xAAAA0000 and port1 = 0x0000BBBB → stored 0x0000BBBB. Write of 0xFFFFFFFF to addr 0 with ZERO_REG=1 → read 0.
- Reserve addr 3 → rpend = 1 next cycle. Write addr 3 → rpend = 0. Simultaneous reserve and write to addr 3 → rpend stays 1 and data is written.
- clear pulse in IDLE with pending[3] = 1 and entry 9 = 0x55: ready low for 32 cycles, writes during clear ignored; afterwards entry 9 reads 0 and rpend[3] reads 0.
- rst asserted at clear cycle 10, held for 2 cycles, then released → a full 32-cycle clear restarts at entry 0.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared types for the integer register bank and its integrating wrapper.
package register_bank_pkg;

    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned DEF_NREG = 32;
    localparam int unsigned DEF_NRD  = 2;
    localparam int unsigned DEF_AW   = $clog2(DEF_NREG);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    typedef struct packed {
        logic                           clear;
        logic [DEF_NRD-1:0]             rden;
        logic [DEF_NRD*DEF_AW-1:0]      raddr;
        logic [1:0]                     wren;
        logic [2*DEF_AW-1:0]            waddr;
        logic [2*DEF_XLEN-1:0]          wdata;
        logic                           rsv_en;
        logic [DEF_AW-1:0]              rsv_addr;
    } register_bank_in_type;

    typedef struct packed {
        logic                           ready;
        logic [DEF_NRD*DEF_XLEN-1:0]    rdata;
        logic [DEF_NRD-1:0]             rpend;
    } register_bank_out_type;

endpackage

// File: rtl/register_bank_scoreboard.sv
// Per-register pending bits: set by reservations, cleared by writes, flushed by a re-clear.
module register_bank_scoreboard
    import register_bank_pkg::*;
#(
    parameter  int unsigned NREG = 32,
    parameter  int unsigned NRD  = 2,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic [1:0]        clr_en,
    input  logic [2*AW-1:0]   clr_addr,
    input  logic [NRD*AW-1:0] look_addr,
    output logic [NRD-1:0]    pend_c
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    // Next pending vector: a reservation overrides a same-cycle write clear.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (clr_en[j]) pend_d[clr_addr[j*AW +: AW]] = 1'b0;
            end
            if (set_en) pend_d[set_addr] = 1'b1;
        end
    end

    // Pending bit storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend_q <= '0;
        else      pend_q <= pend_d;
    end

    // Combinational lookup for each read port.
    always_comb begin
        pend_c = '0;
        for (int i = 0; i < NRD; i++) begin
            pend_c[i] = pend_q[look_addr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/register_bank.sv
// Integer register bank: NRD read ports, two prioritised write ports, optional
// write-to-read bypass, pending scoreboard and a one-entry-per-cycle clear engine.
module register_bank
    import register_bank_pkg::*;
#(
    parameter  int unsigned XLEN     = 32,
    parameter  int unsigned NREG     = 32,
    parameter  int unsigned NRD      = 2,
    parameter  bit          ZERO_REG = 1'b1,
    parameter  bit          BYPASS   = 1'b1,
    localparam int unsigned AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    output logic                ready,
    input  logic [NRD-1:0]      rden,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rpend,
    input  logic [1:0]          wren,
    input  logic [2*AW-1:0]     waddr,
    input  logic [2*XLEN-1:0]   wdata,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr
);

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   cnt_d;
    logic [XLEN-1:0] mem [NREG];
    logic            accept;
    logic            flush;
    logic [1:0]      wr_ok;
    logic            rsv_ok;
    logic [NRD-1:0]  pend_c;

    assign ready  = (state_q == ST_IDLE);
    assign accept = (state_q == ST_IDLE) && !clear;
    assign flush  = (state_q == ST_IDLE) && clear;
    assign rsv_ok = accept && rsv_en && !(ZERO_REG && (rsv_addr == '0));

    // Effective write enables: only in IDLE without a clear request, never to hard-wired entry 0.
    always_comb begin
        wr_ok = '0;
        for (int j = 0; j < 2; j++) begin
            wr_ok[j] = accept && wren[j] && !(ZERO_REG && (waddr[j*AW +: AW] == '0));
        end
    end

    // State and clear-counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk every entry in CLEAR, restart the walk on a clear request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NREG - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage array; no reset, zeroed by the clear engine. Port 1 is written last so it wins.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[cnt_q] <= '0;
        end else begin
            if (wr_ok[0]) mem[waddr[0 +: AW]]  <= wdata[0 +: XLEN];
            if (wr_ok[1]) mem[waddr[AW +: AW]] <= wdata[XLEN +: XLEN];
        end
    end

    // Combinational read ports with optional bypass of this cycle's accepted writes.
    always_comb begin
        logic [AW-1:0] ra;
        ra    = '0;
        rdata = '0;
        rpend = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = raddr[i*AW +: AW];
            if ((state_q == ST_IDLE) && rden[i] && !(ZERO_REG && (ra == '0))) begin
                rdata[i*XLEN +: XLEN] = mem[ra];
                if (BYPASS) begin
                    if (wr_ok[0] && (waddr[0 +: AW] == ra))  rdata[i*XLEN +: XLEN] = wdata[0 +: XLEN];
                    if (wr_ok[1] && (waddr[AW +: AW] == ra)) rdata[i*XLEN +: XLEN] = wdata[XLEN +: XLEN];
                end
                rpend[i] = pend_c[i];
            end
        end
    end

    register_bank_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .set_en    (rsv_ok),
        .set_addr  (rsv_addr),
        .clr_en    (wr_ok),
        .clr_addr  (waddr),
        .look_addr (raddr),
        .pend_c    (pend_c)
    );

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: vector table plus clear/reset sequences.
module tb_register_bank;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic [NRD-1:0]    rden;
    logic [NRD*AW-1:0] raddr;
    logic [1:0]        wren;
    logic [2*AW-1:0]   waddr;
    logic [2*XLEN-1:0] wdata;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;

    logic                ready,    ready_nb;
    logic [NRD*XLEN-1:0] rdata,    rdata_nb;
    logic [NRD-1:0]      rpend,    rpend_nb;

    always #5 clk = ~clk;

    register_bank #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .ready(ready),
        .rden(rden), .raddr(raddr), .rdata(rdata), .rpend(rpend),
        .wren(wren), .waddr(waddr), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    register_bank #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .clear(clear), .ready(ready_nb),
        .rden(rden), .raddr(raddr), .rdata(rdata_nb), .rpend(rpend_nb),
        .wren(wren), .waddr(waddr), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    typedef struct {
        logic        clear;
        logic [1:0]  rden;
        logic [4:0]  ra0, ra1;
        logic [1:0]  wren;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        rsv;
        logic [4:0]  rsva;
    } in_t;

    typedef struct {
        logic        ready;
        logic [31:0] rd0, rd1;
        logic        rp0, rp1;
        logic [31:0] nb0;
    } exp_t;

    typedef struct {
        string name;
        in_t   i;
        exp_t  e;
    } vec_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    vec_t tbl[15];

    function automatic in_t io(logic [1:0] rd_en, logic [4:0] ra0, logic [4:0] ra1,
                               logic [1:0] wr_en, logic [4:0] wa0, logic [4:0] wa1,
                               logic [31:0] wd0, logic [31:0] wd1,
                               logic rsv, logic [4:0] rsva);
        in_t r;
        r.clear = 1'b0; r.rden = rd_en; r.ra0 = ra0; r.ra1 = ra1;
        r.wren = wr_en; r.wa0 = wa0; r.wa1 = wa1; r.wd0 = wd0; r.wd1 = wd1;
        r.rsv = rsv; r.rsva = rsva;
        return r;
    endfunction

    function automatic exp_t ex(logic rdy, logic [31:0] rd0, logic [31:0] rd1,
                                logic rp0, logic rp1, logic [31:0] nb0);
        exp_t r;
        r.ready = rdy; r.rd0 = rd0; r.rd1 = rd1; r.rp0 = rp0; r.rp1 = rp1; r.nb0 = nb0;
        return r;
    endfunction

    function automatic vec_t mkv(string name, in_t i, exp_t e);
        vec_t r;
        r.name = name; r.i = i; r.e = e;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic drive(in_t i);
        clear    = i.clear;
        rden     = i.rden;
        raddr    = {i.ra1, i.ra0};
        wren     = i.wren;
        waddr    = {i.wa1, i.wa0};
        wdata    = {i.wd1, i.wd0};
        rsv_en   = i.rsv;
        rsv_addr = i.rsva;
    endtask

    task automatic compare(string name);
        exp_t e;
        e = exp_q.pop_front();
        check({name, ".ready"}, 32'(ready), 32'(e.ready));
        check({name, ".rdata0"}, rdata[31:0], e.rd0);
        check({name, ".rdata1"}, rdata[63:32], e.rd1);
        check({name, ".rpend0"}, 32'(rpend[0]), 32'(e.rp0));
        check({name, ".rpend1"}, 32'(rpend[1]), 32'(e.rp1));
        check({name, ".nobypass_rdata0"}, rdata_nb[31:0], e.nb0);
    endtask

    // One cycle: drive after the falling edge, sample combinational outputs before the rising edge.
    task automatic step(vec_t v);
        @(negedge clk);
        drive(v.i);
        exp_q.push_back(v.e);
        #2;
        compare(v.name);
    endtask

    // Counts rising edges after reset release; ready must rise exactly on the NREG-th.
    task automatic count_clear(string name);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s.ready_edge%0d", name, k), 32'(ready), 32'(k == 32));
        end
    endtask

    task automatic reset_pulse(string name, int cycles);
        @(negedge clk);
        rst = 1'b0;
        drive(io(2'b11, 5'd9, 5'd31, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0));
        exp_q.push_back(ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        #2;
        compare({name, ".in_reset"});
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
        count_clear(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        in_t idle;
        in_t c;
        int  n;
        idle = io(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0);

        tbl[0]  = mkv("wr5_bypass",  io(2'b11, 5'd5, 5'd5, 2'b01, 5'd5, 5'd0, 32'h12345678, 32'h0, 1'b0, 5'd0),
                      ex(1'b1, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h0));
        tbl[1]  = mkv("rd5",         io(2'b11, 5'd5, 5'd5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                      ex(1'b1, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h12345678));
        tbl[2]  = mkv("dual_wr7",    io(2'b11, 5'd7, 5'd5, 2'b11, 5'd7, 5'd7, 32'hAAAA0000, 32'h0000BBBB, 1'b0, 5'd0),
                      ex(1'b1, 32'h0000BBBB, 32'h12345678, 1'b0, 1'b0, 32'h0));
        tbl[3]  = mkv("wr0_dropped", io(2'b11, 5'd7, 5'd0, 2'b10, 5'd0, 5'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 5'd0),
                      ex(1'b1, 32'h0000BBBB, 32'h0, 1'b0, 1'b0, 32'h0000BBBB));
        tbl[4]  = mkv("rd0_zero",    io(2'b11, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                      ex(1'b1, 32'h0, 32'h0000BBBB, 1'b0, 1'b0, 32'h0));
        tbl[5]  = mkv("rsv3",        io(2'b11, 5'd3, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3),
                      ex(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        tbl[6]  = mkv("rpend3",      io(2'b11, 5'd3, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                      ex(1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0));
        tbl[7]  = mkv("wr3",         io(2'b11, 5'd3, 5'd7, 2'b01, 5'd3, 5'd0, 32'h33, 32'h0, 1'b0, 5'd0),
                      ex(1'b1, 32'h33, 32'h0000BBBB, 1'b1, 1'b0, 32'h0));
        tbl[8]  = mkv("wr3_cleared", io(2'b11, 5'd3, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                      ex(1'b1, 32'h33, 32'h33, 1'b0, 1'b0, 32'h33));
        tbl[9]  = mkv("rsv_wr3",     io(2'b11, 5'd3, 5'd3, 2'b10, 5'd0, 5'd3, 32'h0, 32'h44, 1'b1, 5'd3),
                      ex(1'b1, 32'h44, 32'h44, 1'b0, 1'b0, 32'h33));
        tbl[10] = mkv("rsv_wins",    io(2'b11, 5'd3, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                      ex(1'b1, 32'h44, 32'h44, 1'b1, 1'b1, 32'h44));
        tbl[11] = mkv("rden_off",    io(2'b00, 5'd3, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                      ex(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        tbl[12] = mkv("rden_port0",  io(2'b01, 5'd3, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                      ex(1'b1, 32'h44, 32'h0, 1'b1, 1'b0, 32'h44));
        tbl[13] = mkv("rsv0_wr9",    io(2'b11, 5'd0, 5'd9, 2'b01, 5'd9, 5'd0, 32'h55, 32'h0, 1'b1, 5'd0),
                      ex(1'b1, 32'h0, 32'h55, 1'b0, 1'b0, 32'h0));
        tbl[14] = mkv("rd9",         io(2'b11, 5'd9, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                      ex(1'b1, 32'h55, 32'h44, 1'b0, 1'b1, 32'h55));

        // Power-on reset: outputs held at zero, then exactly NREG clear cycles.
        rst = 1'b0;
        drive(io(2'b11, 5'd5, 5'd5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0));
        repeat (3) @(negedge clk);
        exp_q.push_back(ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        #2;
        compare("por");
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (!ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("por_clear_len", 32'(n), 32'd32);

        // Fill the array with a non-zero pattern so the next clear has something to erase.
        for (int a = 0; a < 32; a++) begin
            step(mkv($sformatf("fill%0d", a),
                     io(2'b01, 5'(a), 5'd0, 2'b01, 5'(a), 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0),
                     ex(1'b1, (a == 0) ? 32'h0 : 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0)));
        end
        step(mkv("fill_rd", io(2'b11, 5'd9, 5'd31, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                 ex(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF)));

        // Reset again: ready low for exactly 32 edges, every entry then reads zero.
        reset_pulse("rst2", 2);
        for (int a = 0; a < 32; a++) begin
            step(mkv($sformatf("zero%0d", a),
                     io(2'b11, 5'(a), 5'(31 - a), 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                     ex(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0)));
        end

        // Main read/write/reserve vectors.
        foreach (tbl[k]) step(tbl[k]);

        // Clear request with pending[3]=1 and entry 9=0x55; writes and reservations during clear are ignored.
        c = io(2'b10, 5'd9, 5'd3, 2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 1'b1, 5'd5);
        c.clear = 1'b1;
        step(mkv("clear_req", c, ex(1'b1, 32'h0, 32'h44, 1'b0, 1'b1, 32'h0)));
        for (int k = 1; k <= 32; k++) begin
            step(mkv($sformatf("clearing%0d", k),
                     io(2'b11, 5'd9, 5'd3, 2'b01, 5'd9, 5'd0, 32'h77, 32'h0, 1'b1, 5'd5),
                     ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0)));
        end
        step(mkv("after_clear", io(2'b11, 5'd9, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                 ex(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0)));
        step(mkv("after_clear_rsv5", io(2'b11, 5'd5, 5'd7, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                 ex(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0)));

        // Reset at clear cycle 10 restarts a full clear from entry 0.
        step(mkv("wr20", io(2'b01, 5'd20, 5'd0, 2'b11, 5'd20, 5'd25, 32'hABCD, 32'h1234, 1'b0, 5'd0),
                 ex(1'b1, 32'hABCD, 32'h0, 1'b0, 1'b0, 32'h0)));
        c = idle;
        c.clear = 1'b1;
        step(mkv("clear_req2", c, ex(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0)));
        for (int k = 1; k <= 10; k++) begin
            step(mkv($sformatf("clearing2_%0d", k), idle, ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0)));
        end
        reset_pulse("rst_mid_clear", 2);
        step(mkv("after_restart", io(2'b11, 5'd20, 5'd25, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0),
                 ex(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0)));
        step(mkv("ready_holds", idle, ex(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
